// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-producer accepted-beat counters.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int BW    = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    localparam logic [BW-1:0]    LAST     = BW'(BURST_MAX - 1);
    localparam logic [PTR_W:0]   NR       = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_MAX < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: parameter out of range");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [PTR_W-1:0]   g;
    logic [PTR_W-1:0]   g_next;
    logic [PTR_W-1:0]   start;
    logic [BW-1:0]      cnt;
    logic [BW-1:0]      cnt_d;
    logic               beat;
    logic               any_valid;
    logic               g_valid;
    logic               rel;

    assign req_ready = grant & {NUM_REQ{~fifo_full}};
    assign beat      = |(req_valid & req_ready);
    assign fifo_wr   = beat;
    assign busy      = (state == GRANT);
    assign g_valid   = |(req_valid & grant);
    assign rel       = (beat && cnt == LAST) || !g_valid;
    assign g_next    = (g == LAST_IDX) ? '0 : g + PTR_W'(1);
    assign start     = (state == IDLE) ? rr_ptr : g_next;

    always_comb begin
        g            = '0;
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g            = PTR_W'(i);
                fifo_data_in = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // First valid requester at or after start, wrapping at NUM_REQ.
    always_comb begin
        logic [PTR_W:0] idx;
        pick      = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, start} + (PTR_W + 1)'(k);
            if (idx >= NR) begin
                idx = idx - NR;
            end
            if (!any_valid && req_valid[idx[PTR_W-1:0]]) begin
                pick[idx[PTR_W-1:0]] = 1'b1;
                any_valid            = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state;
        grant_d  = grant;
        rr_ptr_d = rr_ptr;
        cnt_d    = cnt;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    rr_ptr_d = g_next;
                    cnt_d    = '0;
                    if (any_valid) begin
                        grant_d = pick;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt + BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_d;
            grant  <= grant_d;
            rr_ptr <= rr_ptr_d;
            cnt    <= cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0] accept;

    assign accept = req_valid & req_ready;

    // Saturating counters; clear wins over a same-cycle beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt <= '0;
        end else if (stat_clr) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i] && grant_cnt[i*CNT_W +: CNT_W] != '1) begin
                    grant_cnt[i*CNT_W +: CNT_W] <=
                        grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: producers, a 32-deep FIFO model and a
// transaction-level round-robin reference model around fifo_wr_arbiter.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int BM    = 4;
    localparam int DEPTH = 32;
`ifdef FIFO_ARB_STATS_EN
    localparam int CW = 3;
`else
    localparam int CW = 16;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_data_in;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef FIFO_ARB_STATS_EN
    logic            stat_clr;
    logic [N*CW-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .BURST_MAX(BM),
        .CNT_W    (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_data_in(fifo_data_in),
        .grant       (grant),
        .busy        (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr    (stat_clr),
        .grant_cnt   (grant_cnt)
`endif
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] pdata [N][64];
    int         phead [N];
    int         ptail [N];
    bit         vmask [N];
    logic [7:0] fq[$];
    logic [7:0] wlog[$];
    int         nwr;
    int         overflow;
    bit         rd_pend;
    bit         auto_rd;
    int         m_owner;
    int         m_cnt;
    int         m_ptr;

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = vmask[i] && (phead[i] < ptail[i]);
            if (req_valid[i])
                req_data[i*DW +: DW] = pdata[i][phead[i]];
            else
                req_data[i*DW +: DW] = 8'($urandom);
        end
        fifo_full = (fq.size() >= DEPTH);
    endtask

    task automatic load(input int p, input logic [7:0] v);
        pdata[p][ptail[p]] = v;
        ptail[p]++;
    endtask

    function automatic int pick_from(input int s);
        int r;
        r = -1;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(s + k) % N]) r = (s + k) % N;
        end
        return r;
    endfunction

    // One clock: predict outputs, sample DUT, advance model and environment.
    task automatic advance(output logic [17:0] got, output logic [17:0] want);
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ew;
        logic [7:0]   ed;
        logic [N-1:0] s_ready;
        logic         s_wr;
        logic [7:0]   s_data;
        int           sz;
        @(negedge clk);
        eg   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        er   = fifo_full ? '0 : eg;
        ew   = |(er & req_valid);
        ed   = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : 8'h00;
        want = {eg, er, ew, ed, (m_owner >= 0)};
        got  = {grant, req_ready, fifo_wr, fifo_data_in, busy};
        s_ready = req_ready;
        s_wr    = fifo_wr;
        s_data  = fifo_data_in;
        if (m_owner < 0) begin
            m_owner = pick_from(m_ptr);
            m_cnt   = 0;
        end else begin
            if (ew) m_cnt++;
            if ((ew && m_cnt == BM) || !req_valid[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick_from(m_ptr);
                m_cnt   = 0;
            end
        end
        @(posedge clk);
        #1;
        sz = fq.size();
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && s_ready[i]) phead[i]++;
        end
        if ((rd_pend || auto_rd) && sz > 0) void'(fq.pop_front());
        if (s_wr) begin
            nwr++;
            wlog.push_back(s_data);
            if (sz >= DEPTH) overflow++;
            else fq.push_back(s_data);
        end
        rd_pend = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
            vmask[i] = 1'b0;
        end
        fq.delete();
        wlog.delete();
        nwr      = 0;
        overflow = 0;
        rd_pend  = 1'b0;
        auto_rd  = 1'b0;
        m_owner  = -1;
        m_cnt    = 0;
        m_ptr    = 0;
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [17:0] got, want;
        do_reset();
        for (int i = 0; i < N; i++) begin
            vmask[i] = 1'b1;
            for (int k = 0; k < 4; k++) load(i, 8'(i * 16 + k + 1));
        end
        rst = 1'b0;
        drive_inputs();
        @(negedge clk);
        total += 5;
        if (req_ready !== '0) begin
            bad++;
            $display("FAIL reset_ready got=%b want=0", req_ready);
        end
        if (fifo_wr !== 1'b0) begin
            bad++;
            $display("FAIL reset_wr got=%b want=0", fifo_wr);
        end
        if (grant !== '0) begin
            bad++;
            $display("FAIL reset_grant got=%b want=0", grant);
        end
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        if (fifo_data_in !== '0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", fifo_data_in);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL reset_seq c=%0d got=%h want=%h", c, got, want);
            end
            if (c == 1) begin
                total++;
                if (wlog.size() != 1 || wlog[0] !== 8'h01) begin
                    bad++;
                    $display("FAIL first_beat got_n=%0d want_n=1 want=01",
                             wlog.size());
                end
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (fifo_wr !== 1'b0 || grant !== '0) begin
            bad++;
            $display("FAIL reset_mid got_wr=%b got_g=%b want=0", fifo_wr, grant);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [17:0] got, want;
        do_reset();
        vmask[0] = 1'b1;
        for (int k = 1; k <= 6; k++) load(0, 8'(k));
        drive_inputs();
        for (int c = 0; c < 10; c++) begin
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL single c=%0d got=%h want=%h", c, got, want);
            end
        end
        total++;
        if (nwr != 6) begin
            bad++;
            $display("FAIL single_count got=%0d want=6", nwr);
        end
        for (int k = 1; k <= 6; k++) begin
            total++;
            if (fq.size() == 0 || fq[0] !== 8'(k)) begin
                bad++;
                $display("FAIL single_order k=%0d want=%0d", k, k);
            end
            if (fq.size() > 0) void'(fq.pop_front());
        end
    endtask

    task automatic test_all();
        logic [17:0] got, want;
        int          p, v;
        do_reset();
        auto_rd = 1'b1;
        for (int i = 0; i < N; i++) begin
            vmask[i] = 1'b1;
            for (int k = 0; k < 12; k++) load(i, 8'(i * 16 + k));
        end
        drive_inputs();
        for (int c = 0; c < 49; c++) begin
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL all c=%0d got=%h want=%h", c, got, want);
            end
        end
        total++;
        if (nwr != 48) begin
            bad++;
            $display("FAIL all_count got=%0d want=48", nwr);
        end
        for (int j = 0; j < 48 && j < wlog.size(); j++) begin
            p = (j / 4) % N;
            v = p * 16 + (j / 16) * 4 + j % 4;
            total++;
            if (wlog[j] !== 8'(v)) begin
                bad++;
                $display("FAIL all_order j=%0d got=%h want=%h", j, wlog[j], 8'(v));
            end
        end
    endtask

    task automatic test_full();
        logic [17:0] got, want;
        int          p;
        do_reset();
        for (int j = 0; j < 40; j++) begin
            p = int'($urandom % N);
            load(p, 8'($urandom));
        end
        for (int i = 0; i < N; i++) vmask[i] = 1'b1;
        drive_inputs();
        for (int c = 0; c < 50; c++) begin
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL full c=%0d got=%h want=%h", c, got, want);
            end
        end
        total += 2;
        if (nwr != 32) begin
            bad++;
            $display("FAIL full_count got=%0d want=32", nwr);
        end
        if (fifo_full !== 1'b1) begin
            bad++;
            $display("FAIL full_flag got=%b want=1", fifo_full);
        end
        rd_pend = 1'b1;
        for (int c = 0; c < 6; c++) begin
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL full_rd c=%0d got=%h want=%h", c, got, want);
            end
        end
        total += 2;
        if (nwr != 33) begin
            bad++;
            $display("FAIL full_after_rd got=%0d want=33", nwr);
        end
        if (overflow != 0) begin
            bad++;
            $display("FAIL overflow got=%0d want=0", overflow);
        end
    endtask

    task automatic test_early_release();
        logic [17:0] got, want;
        logic [7:0]  exp_log [10];
        int          drop_c;
        do_reset();
        for (int k = 0; k < 6; k++) load(1, 8'(8'h10 + k));
        for (int k = 0; k < 4; k++) load(2, 8'(8'h20 + k));
        vmask[1] = 1'b1;
        vmask[2] = 1'b1;
        drive_inputs();
        drop_c = -10;
        for (int c = 0; c < 20; c++) begin
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL early c=%0d got=%h want=%h", c, got, want);
            end
            if (drop_c < 0 && phead[1] == 2) begin
                drop_c   = c;
                vmask[1] = 1'b0;
                drive_inputs();
            end else if (c == drop_c + 1) begin
                total++;
                if (grant !== 4'b0100) begin
                    bad++;
                    $display("FAIL early_grant got=%b want=0100", grant);
                end
                vmask[1] = 1'b1;
                drive_inputs();
            end
        end
        exp_log = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h22,
                    8'h23, 8'h12, 8'h13, 8'h14, 8'h15};
        total++;
        if (wlog.size() != 10) begin
            bad++;
            $display("FAIL early_count got=%0d want=10", wlog.size());
        end
        for (int j = 0; j < 10 && j < wlog.size(); j++) begin
            total++;
            if (wlog[j] !== exp_log[j]) begin
                bad++;
                $display("FAIL early_order j=%0d got=%h want=%h", j, wlog[j], exp_log[j]);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] got, want;
        do_reset();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 64; k++) load(i, 8'($urandom));
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) vmask[i] = ($urandom % 4) != 0;
            rd_pend = ($urandom % 3) == 0;
            drive_inputs();
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL random c=%0d got=%h want=%h", c, got, want);
            end
        end
        total++;
        if (overflow != 0) begin
            bad++;
            $display("FAIL random_overflow got=%0d want=0", overflow);
        end
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        logic [17:0] got, want;
        do_reset();
        for (int k = 0; k < 8; k++) load(0, 8'(k));
        for (int k = 0; k < 3; k++) load(3, 8'(8'h30 + k));
        vmask[0] = 1'b1;
        vmask[3] = 1'b1;
        drive_inputs();
        for (int c = 0; c < 20; c++) begin
            advance(got, want);
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL stats c=%0d got=%h want=%h", c, got, want);
            end
        end
        total += 3;
        if (grant_cnt[0 +: CW] !== 3'd7) begin
            bad++;
            $display("FAIL stat_cnt0 got=%0d want=7", grant_cnt[0 +: CW]);
        end
        if (grant_cnt[3*CW +: CW] !== 3'd3) begin
            bad++;
            $display("FAIL stat_cnt3 got=%0d want=3", grant_cnt[3*CW +: CW]);
        end
        if (grant_cnt[CW +: 2*CW] !== '0) begin
            bad++;
            $display("FAIL stat_cnt12 got=%h want=0", grant_cnt[CW +: 2*CW]);
        end
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        total++;
        if (grant_cnt !== '0) begin
            bad++;
            $display("FAIL stat_clr got=%h want=0", grant_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all();
        test_full();
        test_early_release();
        test_random();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin write arbiter that shares the 8-bit synchronous FIFO's write port (`wr`, `data_in`, `full`) among `NUM_REQ` producers.
- Each producer uses a valid/ready handshake. A grant is held for a burst of up to `BURST_MAX` beats, then rotates to the next producer.
- `wr` is gated by `full`, so the FIFO's `overflow` flag can never assert.
- Sits between producer blocks and the FIFO instance. The read side is not touched.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of producers, 2..8.
- `DATA_W`, default 8: beat width; must match the FIFO `data_in` width.
- `BURST_MAX`, default 4: maximum beats per grant, ≥1.
- `CNT_W`, default 16: width of each statistics counter (statistics build only).

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: producer i has a beat available.
- `req_data` in `NUM_REQ*DATA_W`: producer i's beat on `[i*DATA_W +: DATA_W]`.
- `req_ready` out `NUM_REQ`: beat i is accepted at the next rising edge when `req_valid[i]` and `req_ready[i]` are both high.
- `fifo_full` in 1: driven from FIFO `full`.
- `fifo_wr` out 1: driven to FIFO `wr`.
- `fifo_data_in` out `DATA_W`: driven to FIFO `data_in`.
- `grant` out `NUM_REQ`: registered grant, one-hot or zero.
- `busy` out 1: high when `state == GRANT`.
- `stat_clr` in 1: synchronous clear of the counters (statistics build only).
- `grant_cnt` out `NUM_REQ*CNT_W`: accepted-beat count per producer (statistics build only).

## Operation

**Registered state**
- `state` ∈ {IDLE, GRANT}, `grant`, round-robin pointer `rr_ptr`, beat count `cnt`.

**Combinational outputs**
- `req_ready[i] = grant[i] & ~fifo_full`.
- `beat = |(req_valid & req_ready)`.
- `fifo_wr = beat`.
- `fifo_data_in` = granted producer's `req_data` when `grant != 0`, else 0.

**IDLE**
- If any `req_valid` is high, choose the first set bit searching from `rr_ptr` upward, with wrap.
- Load the one-hot `grant`, set `cnt = 0`, go to GRANT.
- Otherwise stay in IDLE.

**GRANT (granted producer g)**
- When `beat` is high: `cnt += 1`.
- `release = (beat & cnt == BURST_MAX-1) | ~req_valid[g]`.
- On release:
  - `rr_ptr = (g+1) mod NUM_REQ`.
  - If any `req_valid` is high this cycle (g included), re-arbitrate from `(g+1) mod NUM_REQ` as in IDLE. Stay in GRANT with the new grant and `cnt = 0`. No dead cycle.
  - Otherwise go to IDLE with `grant = 0`.
- When `fifo_full` is high: `req_ready` is 0, no beat, `cnt` holds, grant holds. There is no timeout while stalled.

**Boundary rules**
- A lone producer is re-granted to itself after each burst.
- `fifo_full` and `req_valid` high on the same cycle: no write.
- A producer is never granted while its `req_valid` is low at the arbitration edge.
- Beat order within a producer is preserved.

**Reset**
- `rst` low immediately clears `state` to IDLE and sets `grant`, `rr_ptr`, `cnt` and counters to 0.
- Outputs during reset: `req_ready = 0`, `fifo_wr = 0`, `fifo_data_in = 0`, `busy = 0`, `grant = 0`, `grant_cnt = 0`.
- A beat pending when reset asserts is not written.

## Timing

- **Request to first beat:** 1 cycle. `req_valid` is sampled at edge N, grant is registered at N, and the first beat is written at edge N+1.
- **Beat to FIFO:** zero latency. The FIFO captures `fifo_data_in` on the same edge the handshake completes.
- **Throughput:** 1 beat per cycle while not full, including across grant rotation.
- **Combinational paths:** `fifo_full`→`req_ready`/`fifo_wr` and `req_data`→`fifo_data_in`. There is no path from `req_valid` to `req_ready`.

## Configuration

- **`FIFO_ARB_STATS_EN` defined:**
  - `stat_clr` and `grant_cnt` exist.
  - Counter i increments on every accepted beat from producer i and saturates at all-ones.
  - When `stat_clr` is high at an edge, all counters become 0. Clear takes priority over increment.
- **`FIFO_ARB_STATS_EN` not defined:** both ports and all counter logic are absent. Arbitration behaviour is identical.

## Test plan

1. **Reset:** hold `rst` low with all `req_valid` high and `fifo_full` low. Required: `req_ready`, `fifo_wr`, `grant`, `busy`, `fifo_data_in` all 0. After release, the first beat is written exactly 1 cycle later, from producer 0.
2. **Single producer:** producer 0 offers data 1..6 continuously, `BURST_MAX=4`. Required:
   - Beats 1..4 are written on consecutive edges.
   - Producer 0 is re-granted with no gap.
   - Beats 5 and 6 follow, then IDLE.
   - The FIFO reads back 1..6 in order.
3. **All producers active:** all four producers continuously valid, producer i sending i*16+k. Required: grant order 0,1,2,3,0,…, 4 beats each, `fifo_wr` high every cycle.
4. **Full back-pressure:** offer 40 beats into an empty 32-deep FIFO with no reads. Required:
   - Exactly 32 writes, then `fifo_wr` stays 0 and `grant` holds.
   - `overflow` never asserts.
   - After 1 read, exactly 1 more beat is written.
5. **Early release:** producer 1 drops `req_valid` after 2 beats while producer 2 is valid. Required: at that edge, grant moves to producer 2 with `cnt = 0`, and producer 1's next request waits for rotation.
6. **Statistics (`FIFO_ARB_STATS_EN`, `CNT_W=3`):** 8 beats from producer 0, 3 beats from producer 3. Required:
   - `grant_cnt[0] = 7` (saturated), `grant_cnt[3] = 3`.
   - After a `stat_clr` pulse, all counters read 0.
